// File: rtl/des_pkg.sv
// des_pkg: shared constants, FSM state type, DES permutation tables, S-boxes and
// helper functions for des_crypt_unrolled and des_round_comb.
// Internally blocks use ascending ranges ([0:N-1]) so index 0 is DES bit 1 (the MSB).
// Functions:
//   des_ip / des_ip_inv : initial permutation and its inverse (64 -> 64)
//   des_e               : expansion (32 -> 48)
//   des_p               : P permutation (32 -> 32)
//   des_key_sel         : pick the 48-bit round key for a round in encrypt/decrypt mode
package des_pkg;

  localparam int DES_ROUNDS     = 16;
  localparam int DES_KEY_BITS   = 48;
  localparam int DES_BLOCK_BITS = 64;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IP_INV_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Row-major: entry index = {row(b1,b6), col(b2..b5)}.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [0:63] des_ip(input logic [0:63] d);
    logic [0:63] o;
    for (int i = 0; i < 64; i++) o[6'(i)] = d[6'(IP_TAB[6'(i)] - 1)];
    return o;
  endfunction

  function automatic logic [0:63] des_ip_inv(input logic [0:63] d);
    logic [0:63] o;
    for (int i = 0; i < 64; i++) o[6'(i)] = d[6'(IP_INV_TAB[6'(i)] - 1)];
    return o;
  endfunction

  function automatic logic [0:47] des_e(input logic [0:31] d);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) o[6'(i)] = d[5'(E_TAB[6'(i)] - 1)];
    return o;
  endfunction

  function automatic logic [0:31] des_p(input logic [0:31] d);
    logic [0:31] o;
    for (int i = 0; i < 32; i++) o[5'(i)] = d[5'(P_TAB[5'(i)] - 1)];
    return o;
  endfunction

  // round is 1-based. Decrypt walks the schedule backwards (round i -> K(17-i)).
  // The 4-bit index keeps out-of-range rounds inside the key vector instead of
  // selecting past its end.
  function automatic logic [0:47] des_key_sel(input logic [0:767] keys,
                                              input logic [4:0]   round,
                                              input logic         mode);
    logic [3:0]   idx;
    logic [0:767] sh;
    idx = mode ? 4'(5'd16 - round) : 4'(round - 5'd1);
    sh  = keys << (48 * idx);
    return sh[0:47];
  endfunction

endpackage

// File: rtl/des_round_comb.sv
// des_round_comb: one purely combinational DES Feistel round.
// Ports:
//   l, r    in  [1:32] : current halves
//   key     in  [1:48] : round key Kn
//   l_next  out [1:32] : R
//   r_next  out [1:32] : L xor f(R, Kn)
module des_round_comb (
  input  logic [1:32] l,
  input  logic [1:32] r,
  input  logic [1:48] key,
  output logic [1:32] l_next,
  output logic [1:32] r_next
);
  import des_pkg::*;

  logic [0:47] x;
  logic [0:31] s;

  assign x = des_e(r) ^ key;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    // Row from the outer bits, column from the inner four.
    assign s[4*g +: 4] = 4'(SBOX[g][{x[6*g], x[6*g+5], x[6*g+1 +: 4]}]);
  end

  assign l_next = r;
  assign r_next = l ^ des_p(s);

endmodule

// File: rtl/des_crypt_unrolled.sv
// des_crypt_unrolled: DES encrypt/decrypt core evaluating ROUNDS_PER_CYCLE chained
// Feistel rounds per clock (1, 2, 4, 8 or 16).
// Optional build macro: DES_KEY_LATCH_EN registers all 768 round-key bits on accept;
// without it round_keys must stay stable from start through done.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, message/decrypt/round_keys valid this cycle
//   decrypt    : 0 = encrypt, 1 = decrypt (sampled with start)
//   message    : [1:64] input block, bit 1 = MSB
//   round_keys : [1:768] K1..K16, K1 in [1:48]
//   busy       : block in flight (start ignored)
//   done       : one-cycle pulse, result valid
//   result     : [1:64] IP^-1(R16||L16), held until next accepted start
module des_crypt_unrolled #(
  parameter int unsigned ROUNDS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [1:64]  message,
  input  logic [1:768] round_keys,
  output logic         busy,
  output logic         done,
  output logic [1:64]  result
);
  import des_pkg::*;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] RStep = 5'(ROUNDS_PER_CYCLE);

  state_t       state_q, state_d;
  logic [1:32]  l_q, l_d, r_q, r_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         accept;
  logic [1:64]  ip_msg;
  logic [1:768] keys;
  logic [1:32]  l_last, r_last;

`ifdef DES_KEY_LATCH_EN
  logic [1:768] keys_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q <= '0;
    end else if (accept) begin
      keys_q <= round_keys;
    end
  end

  assign keys = keys_q;
`else
  assign keys = round_keys;
`endif

  assign ip_msg = des_ip(message);

  // Rounds cnt+1 .. cnt+R, chained without intermediate registers.
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [1:32] l_in, r_in, l_out, r_out;
    logic [1:48] key_g;

    if (g == 0) begin : g_first
      assign l_in = l_q;
      assign r_in = r_q;
    end else begin : g_chain
      assign l_in = g_round[g-1].l_out;
      assign r_in = g_round[g-1].r_out;
    end

    assign key_g = des_key_sel(keys, cnt_q + 5'(g + 1), mode_q);

    des_round_comb u_round (
      .l      (l_in),
      .r      (r_in),
      .key    (key_g),
      .l_next (l_out),
      .r_next (r_out)
    );
  end

  assign l_last = g_round[ROUNDS_PER_CYCLE-1].l_out;
  assign r_last = g_round[ROUNDS_PER_CYCLE-1].r_out;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      StIdle: accept = start;
      StRun: begin
        busy  = 1'b1;
        l_d   = l_last;
        r_d   = r_last;
        cnt_d = cnt_q + RStep;
        if (cnt_q + RStep == 5'd16) state_d = StDone;
      end
      StDone: begin
        done   = 1'b1;
        accept = start;
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      l_d     = ip_msg[1:32];
      r_d     = ip_msg[33:64];
      cnt_d   = 5'd0;
      mode_d  = decrypt;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Final swap folded into the output permutation.
  assign result = des_ip_inv({r_q, l_q});

endmodule

// File: doc/des_crypt_unrolled.md
# des_crypt_unrolled

Parametrised DES encrypt/decrypt core. It processes one 64-bit block per request, running `ROUNDS_PER_CYCLE` Feistel rounds per clock, from a fully iterative core (1) up to a fully unrolled one (16). It sits between the key-schedule block, which supplies all 16 round keys, and the system-level cipher controller. It adds runtime decrypt mode, a busy indicator and back-to-back acceptance.

## Interface
- `ROUNDS_PER_CYCLE`, default 4: Feistel rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `start` in 1: request; `message` is valid this cycle.
- `decrypt` in 1: 0 = encrypt, 1 = decrypt. Sampled with `start`.
- `message` in [1:64]: input block, DES bit numbering (bit 1 = MSB).
- `round_keys` in [1:768]: K1..K16, 48 bits each; K1 occupies [1:48].
- `busy` out 1: high while a block is in flight; `start` is ignored while high.
- `done` out 1: single-cycle pulse, `result` valid.
- `result` out [1:64]: output block; holds until the next accepted `start`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **Accept:** `start` in IDLE or DONE.
  - Load L||R <= IP(message).
  - Round counter <= 0.
  - Latch `decrypt` into `mode_q`.
  - Go to RUN.
- **RUN:** each cycle applies rounds cnt+1 .. cnt+R, where R = `ROUNDS_PER_CYCLE`, then cnt += R.
  - Each round computes L' = R, R' = L xor f(R, Kn).
  - When cnt+R == 16, go to DONE.
- **Key order:**
  - Encrypt: round i uses Ki.
  - Decrypt: round i uses K(17-i).
- **DONE:** `done`=1 for exactly one cycle, then IDLE unless `start` is accepted in that cycle.
- **Output:** `result` = IP^-1(R16||L16), with the final swap. It is driven from the held L/R registers and stays stable in IDLE.
- `busy` = (state == RUN).
- `start` during RUN is dropped with no side effects. The requester must retry after `done`.
- Counter width is 5 bits. It never exceeds 16; no wrap.
- **Reset (at any time, including mid-RUN):**
  - State goes to IDLE; L/R, counter and `mode_q` go to 0.
  - `busy`=0, `done`=0, `result`=IP^-1(0)=64'h0.
  - An in-flight block is discarded with no `done`.

## Timing
- `start` is sampled at edge E0. RUN spans edges E1 .. E(16/R).
- `done` is high in the cycle after edge E(16/R):
  - R=16: 1 cycle
  - R=4: 4 cycles
  - R=1: 16 cycles
- **Back-to-back:** `start` in the DONE cycle is accepted.
  - Throughput is one block per 16/R+1 cycles.
  - `result` of the previous block stays valid through the DONE cycle.
- The critical path is R chained rounds. There is no register between rounds within a cycle.

## Configuration
- `DES_KEY_LATCH_EN`
  - **Defined:** all 768 key bits are registered at accept. `round_keys` may change freely after the `start` cycle.
  - **Undefined:** no key register. `round_keys` must be held stable from `start` through `done`; the bench asserts this. Saves 768 flops.

## Structure
- **Package `des_pkg`:**
  - Constants `DES_ROUNDS=16`, `DES_KEY_BITS=48`, `DES_BLOCK_BITS=64`.
  - S-box tables.
  - IP, IP^-1, E and P permutation functions.
  - Function `des_key_sel(keys, round, mode)` returning the 48-bit key slice.
- **Sub-module `des_round_comb`:**
  - One combinational Feistel round: inputs L, R, Kn; outputs L', R'.
  - Instantiated R times in a generate chain.

## Test plan
- **Encrypt, R=4:** schedule from key 133457799BBCDFF1, message 0123456789ABCDEF -> `done` 4 cycles after `start`, result 85E813540F0AB405.
- **Decrypt, same keys:** message 85E813540F0AB405, `decrypt`=1 -> result 0123456789ABCDEF.
- **Parameter sweep R=1,2,8,16:** key 0E329232EA6D0D73, message 8787878787878787 -> result 0000000000000000, latency 16, 8, 2, 1 cycles.
- **Overlapped start:** `start` pulsed mid-RUN -> ignored, single `done`, correct result. Then `start` in the DONE cycle -> second block accepted, second `done` 16/R+1 cycles after the first.
- **Reset mid-RUN:** `rst` asserted after 2 RUN cycles -> `busy`=0, `done` never pulses, `result`=0. A new request afterwards completes correctly.
- **With `DES_KEY_LATCH_EN` defined:** `round_keys` randomised after `start` -> result unchanged (85E813540F0AB405 vector).
